// File: rtl/store_trace_unit.sv
// Store trace capture: watches the core's data-port stores, buffers them in a FIFO
// for a downstream consumer, and decides PASS/FAIL/TIMEOUT from a halt-address store.
module store_trace_unit #(
    parameter int unsigned DEPTH      = 8,
    parameter logic [31:0] HALT_ADDR  = 32'h0000_00FC,
    parameter int unsigned MAX_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic [31:0] WriteData,
    input  logic [31:0] DataAdr,
    input  logic        start,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,
    output logic        done,
    output logic [1:0]  status,
    output logic        overflow,
    output logic [7:0]  drop_count
);

    localparam int AW  = $clog2(DEPTH);
    localparam int WDW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [WDW-1:0]  WD_LAST   = WDW'(MAX_CYCLES - 1);
    localparam logic [AW:0]     FULL_CNT  = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t         state, state_nxt;
    logic           done_nxt;
    logic [1:0]     status_nxt;
    logic [WDW-1:0] wdog;

    logic [31:0]    mem_addr [DEPTH];
    logic [31:0]    mem_data [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [AW:0]    count, count_nxt, count_after_pop;

    logic           halt_hit, push_req, push_acc, pop, full, drop, head_bypass;

    assign halt_hit = (state == S_RUN) && MemWrite && (DataAdr == HALT_ADDR);
    assign push_req = (state == S_RUN) && MemWrite && (DataAdr != HALT_ADDR);
    assign pop      = out_valid && out_ready;
    assign full     = (count == FULL_CNT);
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign push_acc = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    assign count_after_pop = count - (AW+1)'(pop);
    assign count_nxt       = count_after_pop + (AW+1)'(push_acc);
    assign rd_ptr_nxt      = pop ? rd_ptr + AW'(1) : rd_ptr;
    // When the FIFO drains to empty this edge, the incoming store becomes the new head.
    assign head_bypass     = push_acc && (count_after_pop == '0);

    // State register plus registered done/status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            done   <= 1'b0;
            status <= 2'b00;
        end else begin
            state  <= state_nxt;
            done   <= done_nxt;
            status <= status_nxt;
        end
    end

    // Next-state logic; a halt store beats watchdog expiry in the same cycle
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_RUN;
            S_RUN: begin
                if (halt_hit)
                    state_nxt = (WriteData == 32'd1) ? S_PASS : S_FAIL;
                else if (wdog == WD_LAST)
                    state_nxt = S_TIMEOUT;
            end
            default: state_nxt = state;
        endcase
    end

    // Output decode, evaluated on the next state so the registers track the transition edge
    always_comb begin
        done_nxt   = 1'b0;
        status_nxt = 2'b00;
        case (state_nxt)
            S_PASS:    begin done_nxt = 1'b1; status_nxt = 2'b01; end
            S_FAIL:    begin done_nxt = 1'b1; status_nxt = 2'b10; end
            S_TIMEOUT: begin done_nxt = 1'b1; status_nxt = 2'b11; end
            default:   begin done_nxt = 1'b0; status_nxt = 2'b00; end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wdog <= '0;
        else if (state == S_RUN)
            wdog <= wdog + WDW'(1);
        else
            wdog <= '0;
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_addr[wr_ptr] <= DataAdr;
            mem_data[wr_ptr] <= WriteData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= sat_inc8(drop_count);
            end
        end
    end

    // Registered FIFO head presented to the consumer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_addr  <= 32'd0;
            out_data  <= 32'd0;
        end else begin
            out_valid <= (count_nxt != '0);
            if (head_bypass) begin
                out_addr <= DataAdr;
                out_data <= WriteData;
            end else if (count_nxt != '0) begin
                out_addr <= mem_addr[rd_ptr_nxt];
                out_data <= mem_data[rd_ptr_nxt];
            end
        end
    end

endmodule

// File: tb/tb_store_trace_unit.sv
// Directed self-checking bench for store_trace_unit (DEPTH=8, MAX_CYCLES=20).
module tb_store_trace_unit;

    localparam int          DEPTH     = 8;
    localparam logic [31:0] HALT_ADDR = 32'h0000_00FC;
    localparam int          MAXC      = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemWrite;
    logic [31:0] WriteData;
    logic [31:0] DataAdr;
    logic        start;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic        done;
    logic [1:0]  status;
    logic        overflow;
    logic [7:0]  drop_count;

    int vectors     = 0;
    int miscompares = 0;

    store_trace_unit #(
        .DEPTH      (DEPTH),
        .HALT_ADDR  (HALT_ADDR),
        .MAX_CYCLES (MAXC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MemWrite   (MemWrite),
        .WriteData  (WriteData),
        .DataAdr    (DataAdr),
        .start      (start),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .done       (done),
        .status     (status),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        tick();
        MemWrite  = 1'b0;
    endtask

    initial begin
        rst = 1'b0; MemWrite = 1'b0; WriteData = '0; DataAdr = '0;
        start = 1'b0; out_ready = 1'b0;
        tick();
        tick();

        // Values held during reset
        check("rst_valid",  32'(out_valid),  32'd0);
        check("rst_addr",   out_addr,        32'd0);
        check("rst_data",   out_data,        32'd0);
        check("rst_done",   32'(done),       32'd0);
        check("rst_status", 32'(status),     32'd0);
        check("rst_ovf",    32'(overflow),   32'd0);
        check("rst_drops",  32'(drop_count), 32'd0);

        rst = 1'b1;
        tick();
        store(32'h20, 32'h5);
        tick();
        check("idle_store_ignored", 32'(out_valid), 32'd0);

        // Two stores drained in order, first one pushed into an empty FIFO with ready high
        do_start();
        out_ready = 1'b1;
        MemWrite = 1'b1; DataAdr = 32'h10; WriteData = 32'hA;
        tick();
        check("s1_valid", 32'(out_valid), 32'd1);
        check("s1_addr",  out_addr,       32'h10);
        check("s1_data",  out_data,       32'hA);
        DataAdr = 32'h14; WriteData = 32'hB;
        tick();
        MemWrite = 1'b0;
        check("s2_valid", 32'(out_valid), 32'd1);
        check("s2_addr",  out_addr,       32'h14);
        check("s2_data",  out_data,       32'hB);
        tick();
        check("s2_drained", 32'(out_valid), 32'd0);
        check("s2_ovf",     32'(overflow),   32'd0);

        // Halt store with data 1 -> PASS, not enqueued
        check("pre_halt_done", 32'(done), 32'd0);
        store(HALT_ADDR, 32'd1);
        check("pass_done",   32'(done),      32'd1);
        check("pass_status", 32'(status),    32'd1);
        check("pass_nopush", 32'(out_valid), 32'd0);
        do_start();
        store(32'h40, 32'h1);
        check("pass_sticky", 32'(status),    32'd1);
        check("term_ignore", 32'(out_valid), 32'd0);

        // Halt store with other data -> FAIL
        do_reset();
        do_start();
        store(HALT_ADDR, 32'd3);
        check("fail_done",   32'(done),   32'd1);
        check("fail_status", 32'(status), 32'd2);

        // Overflow: DEPTH+3 stores with consumer stalled
        do_reset();
        do_start();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) store(32'h100 + 32'(4 * i), 32'(i + 1));
        check("ovf_drops", 32'(drop_count), 32'd3);
        check("ovf_flag",  32'(overflow),   32'd1);
        check("ovf_head",  out_addr,        32'h100);
        // Full FIFO with simultaneous push and pop: no drop
        out_ready = 1'b1;
        store(32'h200, 32'h99);
        check("fullpp_drops", 32'(drop_count), 32'd3);
        for (int i = 1; i < DEPTH; i++) begin
            check($sformatf("drain_addr%0d", i), out_addr, 32'h100 + 32'(4 * i));
            check($sformatf("drain_data%0d", i), out_data, 32'(i + 1));
            tick();
        end
        check("drain_last_addr", out_addr, 32'h200);
        check("drain_last_data", out_data, 32'h99);
        tick();
        check("drain_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Watchdog expiry after exactly MAXC RUN cycles
        do_reset();
        do_start();
        for (int i = 0; i < MAXC - 1; i++) tick();
        check("wd_not_yet", 32'(status), 32'd0);
        tick();
        check("wd_status", 32'(status), 32'd3);
        check("wd_done",   32'(done),   32'd1);

        // Halt store on the expiry cycle wins
        do_reset();
        do_start();
        for (int i = 0; i < MAXC - 1; i++) tick();
        store(HALT_ADDR, 32'd1);
        check("wd_tie_status", 32'(status), 32'd1);

        // Reset mid-run with buffered entries
        do_reset();
        do_start();
        for (int i = 0; i < 4; i++) store(32'h300 + 32'(4 * i), 32'(i));
        check("mid_valid", 32'(out_valid), 32'd1);
        rst = 1'b0;
        #1;
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_addr",  out_addr,       32'd0);
        tick();
        rst = 1'b1;
        tick();
        store(32'h30, 32'h1);
        store(32'h34, 32'h2);
        tick();
        check("post_rst_idle",   32'(out_valid), 32'd0);
        check("post_rst_status", 32'(status),    32'd0);
        do_start();
        check("post_start_empty", 32'(out_valid), 32'd0);
        store(32'h38, 32'h77);
        check("post_start_valid", 32'(out_valid), 32'd1);
        check("post_start_addr",  out_addr,       32'h38);
        check("post_start_data",  out_data,       32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
